// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD host sequencer.
package gcd_pkg;

  localparam int GCD_WIDTH   = 16;
  localparam int GCD_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } gcd_seq_state_t;

endpackage

// File: rtl/gcd_host_sequencer_if.sv
// Request, engine and response signals between the sequencer (master) and its environment (slave).
interface gcd_host_sequencer_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_data_in;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_gcd;
  logic             rsp_timeout;

  modport master (
    input  req_valid, req_a, req_b, gcd_done, gcd_result, rsp_ready,
    output req_ready, gcd_start, gcd_data_in, rsp_valid, rsp_gcd, rsp_timeout
  );

  modport slave (
    output req_valid, req_a, req_b, gcd_done, gcd_result, rsp_ready,
    input  req_ready, gcd_start, gcd_data_in, rsp_valid, rsp_gcd, rsp_timeout
  );
endinterface

// File: rtl/gcd_timeout_counter.sv
// Wait-cycle counter: clears on request, counts while enabled, flags the last allowed cycle.
module gcd_timeout_counter
  import gcd_pkg::*;
#(
  parameter int LIMIT = GCD_TIMEOUT,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire = (cnt_q == LAST);

  // Holding at LAST keeps the count from wrapping even if enable lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/gcd_host_sequencer.sv
// Serialises operand pairs onto the GCD engine bus, waits for done with a timeout guard,
// and returns the result (or a zero bypass/abort result) on the response port.
module gcd_host_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  gcd_host_sequencer_if.master bus,
  output logic                 busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  gcd_seq_state_t   state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_gcd_q, rsp_gcd_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  logic             req_ready_c;
  logic             start_c;
  logic [WIDTH-1:0] data_c;
  logic             rsp_valid_c;
  logic             busy_c;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_expire;

  gcd_timeout_counter #(
    .LIMIT (TIMEOUT),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expire (cnt_expire)
  );

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_gcd_d     = rsp_gcd_q;
    rsp_timeout_d = rsp_timeout_q;
    req_ready_c   = 1'b0;
    start_c       = 1'b0;
    data_c        = '0;
    rsp_valid_c   = 1'b0;
    busy_c        = 1'b1;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_c      = 1'b0;
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          a_d = bus.req_a;
          b_d = bus.req_b;
          // A zero operand makes the answer the other operand; skip the engine.
          if (bus.req_a == '0) begin
            rsp_gcd_d     = bus.req_b;
            rsp_timeout_d = 1'b0;
            state_d       = ST_RESP;
          end else if (bus.req_b == '0) begin
            rsp_gcd_d     = bus.req_a;
            rsp_timeout_d = 1'b0;
            state_d       = ST_RESP;
          end else begin
            state_d = ST_LOAD_A;
          end
        end
      end
      ST_LOAD_A: begin
        start_c = 1'b1;
        data_c  = a_q;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        data_c    = b_q;
        cnt_clear = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.gcd_done) begin
          rsp_gcd_d     = bus.gcd_result;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (cnt_expire) begin
          rsp_gcd_d     = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy_c  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      rsp_gcd_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp_gcd_q     <= rsp_gcd_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Reset is synchronous, so the state may still be live during the rst cycle; mask it.
  assign bus.req_ready   = req_ready_c & ~rst;
  assign bus.gcd_start   = start_c & ~rst;
  assign bus.gcd_data_in = rst ? '0 : data_c;
  assign bus.rsp_valid   = rsp_valid_c & ~rst;
  assign bus.rsp_gcd     = rsp_gcd_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign busy            = busy_c & ~rst;
endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Self-checking bench: cycle-level engine model plus a response scoreboard.
module tb_gcd_host_sequencer;
  import gcd_pkg::*;

  localparam int W  = 16;
  localparam int TO = 8;

  typedef struct packed {
    logic [W-1:0] gcd;
    logic         to;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  gcd_host_sequencer_if #(.WIDTH(W)) bus ();

  gcd_host_sequencer #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int           acc_cyc, start_cyc, b_cyc, rspv_cyc, start_cnt;
  logic [W-1:0] obs_a, obs_b, obs_gcd;
  logic         obs_to;
  bit           got_rsp, unstable, rdy_in_resp;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Runs one request to its response handshake; cycle k=0 is the first cycle inside the task.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int delay,
                         input bit hang, input bit stale, input int hold, input bit chain,
                         input logic [W-1:0] na, input logic [W-1:0] nb);
    bit fin;
    acc_cyc = -1; start_cyc = -1; b_cyc = -1; rspv_cyc = -1; start_cnt = 0;
    obs_a = '0; obs_b = '0; obs_gcd = '0; obs_to = 1'b0;
    got_rsp = 0; unstable = 0; rdy_in_resp = 0; fin = 0;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(negedge clk);
      if (acc_cyc < 0) begin
        bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b;
      end else if (chain) begin
        bus.req_valid = 1'b1; bus.req_a = na; bus.req_b = nb;
      end else begin
        bus.req_valid = 1'b0;
      end
      if (stale && (b_cyc < 0 || k <= b_cyc)) begin
        bus.gcd_done = 1'b1; bus.gcd_result = 16'd99;
      end else if (!hang && b_cyc >= 0 && k >= b_cyc + delay) begin
        bus.gcd_done = 1'b1; bus.gcd_result = gcd_ref(a, b);
      end else begin
        bus.gcd_done = 1'b0; bus.gcd_result = 16'hDEAD;
      end
      #1;
      if (acc_cyc < 0 && bus.req_valid && bus.req_ready) acc_cyc = k;
      if (bus.gcd_start) begin
        start_cnt++;
        if (start_cyc < 0) begin
          start_cyc = k; obs_a = bus.gcd_data_in;
        end
      end
      if (start_cyc >= 0 && k == start_cyc + 1) begin
        b_cyc = k; obs_b = bus.gcd_data_in;
      end
      if (bus.rsp_valid) begin
        if (rspv_cyc < 0) begin
          rspv_cyc = k; obs_gcd = bus.rsp_gcd; obs_to = bus.rsp_timeout;
        end else if (bus.rsp_gcd !== obs_gcd || bus.rsp_timeout !== obs_to) begin
          unstable = 1;
        end
        if (bus.req_ready) rdy_in_resp = 1;
        bus.rsp_ready = (k >= rspv_cyc + hold);
        if (bus.rsp_ready) fin = 1;
      end else begin
        bus.rsp_ready = 1'b0;
      end
    end
    if (fin) begin
      got_rsp = 1;
      @(posedge clk);
    end
    $display("job a=%0d b=%0d acc@%0d rsp@%0d rsp_gcd=%0d rsp_timeout=%0d starts=%0d",
             a, b, acc_cyc, rspv_cyc, obs_gcd, obs_to, start_cnt);
  endtask

  task automatic check_rsp(input string name);
    exp_t e;
    n_vec++;
    if (!got_rsp || sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no response within budget (got_rsp=%0d queued=%0d), required one",
               name, got_rsp, sb_q.size());
      if (sb_q.size() != 0) e = sb_q.pop_front();
    end else begin
      e = sb_q.pop_front();
      if (obs_gcd !== e.gcd || obs_to !== e.to) begin
        n_err++;
        $display("FAIL %s: rsp_gcd=%0d rsp_timeout=%0d, required %0d/%0d",
                 name, obs_gcd, obs_to, e.gcd, e.to);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_a = 16'd5; bus.req_b = 16'd7;
    bus.rsp_ready = 1'b0; bus.gcd_done = 1'b0; bus.gcd_result = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.req_ready, bus.gcd_start, bus.rsp_valid, busy} !== 4'b0 || bus.gcd_data_in !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b start=%b vld=%b busy=%b data=%0d, required all 0",
               bus.req_ready, bus.gcd_start, bus.rsp_valid, busy, bus.gcd_data_in);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_gcd !== '0 || bus.rsp_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b busy=%b rsp_gcd=%0d rsp_to=%b, required 1/0/0/0",
               bus.req_ready, busy, bus.rsp_gcd, bus.rsp_timeout);
    end
  endtask

  task automatic test_engine_job();
    sb_q.push_back('{gcd: gcd_ref(16'd48, 16'd18), to: 1'b0});
    run_job(16'd48, 16'd18, 5, 0, 0, 0, 0, '0, '0);
    check_rsp("engine_48_18");
    n_vec++;
    if (start_cnt != 1 || obs_a !== 16'd48 || obs_b !== 16'd18) begin
      n_err++;
      $display("FAIL engine_bus: starts=%0d A=%0d B=%0d, required 1/48/18", start_cnt, obs_a, obs_b);
    end
    n_vec++;
    if (start_cyc != acc_cyc + 1 || b_cyc != acc_cyc + 2 || rspv_cyc != b_cyc + 6) begin
      n_err++;
      $display("FAIL engine_latency: acc=%0d start=%0d b=%0d rsp=%0d, required start=acc+1 b=acc+2 rsp=b+6",
               acc_cyc, start_cyc, b_cyc, rspv_cyc);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    ta = '{16'd0, 16'd21, 16'd0};
    tb = '{16'd35, 16'd0, 16'd0};
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{gcd: gcd_ref(ta[i], tb[i]), to: 1'b0});
      run_job(ta[i], tb[i], 1, 0, 0, 0, 0, '0, '0);
      check_rsp("bypass");
      n_vec++;
      if (start_cnt != 0 || rspv_cyc != acc_cyc + 1) begin
        n_err++;
        $display("FAIL bypass_timing: starts=%0d acc=%0d rsp=%0d, required 0 starts and rsp=acc+1",
                 start_cnt, acc_cyc, rspv_cyc);
      end
    end
  endtask

  task automatic test_timeout();
    sb_q.push_back('{gcd: '0, to: 1'b1});
    run_job(16'd33, 16'd11, 1, 1, 0, 0, 0, '0, '0);
    check_rsp("timeout_abort");
    n_vec++;
    if (rspv_cyc - b_cyc - 1 != TO) begin
      n_err++;
      $display("FAIL timeout_wait_cycles: %0d, required %0d", rspv_cyc - b_cyc - 1, TO);
    end
    sb_q.push_back('{gcd: gcd_ref(16'd12, 16'd8), to: 1'b0});
    run_job(16'd12, 16'd8, 2, 0, 0, 0, 0, '0, '0);
    check_rsp("after_timeout");
    n_vec++;
    if (acc_cyc != 0) begin
      n_err++;
      $display("FAIL after_timeout_accept: accepted at %0d, required 0", acc_cyc);
    end
  endtask

  task automatic test_backpressure();
    sb_q.push_back('{gcd: gcd_ref(16'd100, 16'd75), to: 1'b0});
    run_job(16'd100, 16'd75, 4, 0, 0, 3, 1, 16'd7, 16'd21);
    check_rsp("backpressure");
    n_vec++;
    if (unstable || rdy_in_resp) begin
      n_err++;
      $display("FAIL backpressure_hold: unstable=%0d req_ready_in_resp=%0d, required 0/0",
               unstable, rdy_in_resp);
    end
    sb_q.push_back('{gcd: gcd_ref(16'd7, 16'd21), to: 1'b0});
    run_job(16'd7, 16'd21, 2, 0, 0, 0, 0, '0, '0);
    check_rsp("pending_after_handshake");
    n_vec++;
    if (acc_cyc != 0) begin
      n_err++;
      $display("FAIL pending_accept: accepted at %0d, required 0", acc_cyc);
    end
  endtask

  task automatic test_done_corners();
    sb_q.push_back('{gcd: gcd_ref(16'd18, 16'd12), to: 1'b0});
    run_job(16'd18, 16'd12, 3, 0, 1, 0, 0, '0, '0);
    check_rsp("stale_done");
    n_vec++;
    if (rspv_cyc != b_cyc + 4) begin
      n_err++;
      $display("FAIL stale_done_latency: rsp=%0d, required %0d", rspv_cyc, b_cyc + 4);
    end
    sb_q.push_back('{gcd: gcd_ref(16'd27, 16'd18), to: 1'b0});
    run_job(16'd27, 16'd18, TO, 0, 0, 0, 0, '0, '0);
    check_rsp("done_at_expiry");
    n_vec++;
    if (rspv_cyc != b_cyc + TO + 1) begin
      n_err++;
      $display("FAIL done_at_expiry_latency: rsp=%0d, required %0d", rspv_cyc, b_cyc + TO + 1);
    end
  endtask

  task automatic test_reset_mid_job();
    bit seen;
    @(negedge clk);
    bus.rsp_ready = 1'b0; bus.gcd_done = 1'b0;
    bus.req_valid = 1'b1; bus.req_a = 16'd40; bus.req_b = 16'd30;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_job_busy: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_job_rst_outputs: busy=%b rdy=%b vld=%b, required 0/0/0",
               busy, bus.req_ready, bus.rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.rsp_gcd !== '0) begin
      n_err++;
      $display("FAIL mid_job_after_rst: rdy=%b vld=%b busy=%b rsp_gcd=%0d, required 1/0/0/0",
               bus.req_ready, bus.rsp_valid, busy, bus.rsp_gcd);
    end
    seen = 0;
    repeat (TO + 4) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid || bus.gcd_start) seen = 1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL mid_job_silent: response or start after abort=%0d, required 0", seen);
    end
    sb_q.push_back('{gcd: gcd_ref(16'd9, 16'd6), to: 1'b0});
    run_job(16'd9, 16'd6, 2, 0, 0, 0, 0, '0, '0);
    check_rsp("after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_engine_job();
    test_bypass();
    test_timeout();
    test_backpressure();
    test_done_corners();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gcd_host_sequencer.md
Name: gcd_host_sequencer

Overview:
Initiator side of the GCD engine's start/done interface. Accepts operand pairs from an upstream valid/ready request port and serialises them onto the engine's shared operand bus: A first, then B. Pulses start, waits for done with a timeout guard, then returns the captured result on a valid/ready response port. Sits between the system bus/CPU glue and the GCD datapath+controller pair.

Parameters:
WIDTH, 16, operand/result width in bits
TIMEOUT, 1023, max WAIT cycles before abort (>=1)
CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  upstream operand pair valid
req_ready  output  1  sequencer can accept a pair
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
gcd_start  output  1  one-cycle start pulse to engine controller
gcd_data_in  output  WIDTH  engine shared operand bus
gcd_done  input  1  engine completion flag (level, held in engine final state)
gcd_result  input  WIDTH  engine A register (valid while gcd_done=1)
rsp_valid  output  1  response valid
rsp_ready  input  1  downstream accepts response
rsp_gcd  output  WIDTH  result
rsp_timeout  output  1  result is an abort, rsp_gcd=0
busy  output  1  state != IDLE

Behaviour:
- One clock, synchronous active-high reset; all registers update on posedge clk only.
- Reset: state=IDLE, a_q=b_q=0, cnt=0, rsp_gcd=0, rsp_timeout=0. While rst=1, outputs are req_ready=0, gcd_start=0, gcd_data_in=0, rsp_valid=0, busy=0. Reset mid-job aborts silently: no response is issued and the engine is not signalled.
- States: IDLE, LOAD_A, LOAD_B, WAIT, RESP (encoding in package).
- IDLE: req_ready=1. On req_valid, capture a_q/b_q.
  - Both nonzero -> LOAD_A.
  - a==0 -> RESP, rsp_gcd=b.
  - b==0 (a!=0) -> RESP, rsp_gcd=a.
  - Bypass cases: rsp_timeout=0, engine untouched. (0,0) gives 0.
- LOAD_A: gcd_start=1, gcd_data_in=a_q -> LOAD_B.
- LOAD_B: gcd_start=0, gcd_data_in=b_q, cnt cleared -> WAIT. gcd_done is ignored here.
- WAIT: gcd_data_in=0.
  - gcd_done=1: rsp_gcd<=gcd_result, rsp_timeout<=0 -> RESP.
  - Else if cnt==TIMEOUT-1: rsp_gcd<=0, rsp_timeout<=1 -> RESP.
  - Else cnt<=cnt+1. Done takes priority over timeout in the same cycle.
- RESP: rsp_valid=1; rsp_gcd and rsp_timeout are held stable until rsp_ready. On rsp_ready -> IDLE. req_ready=0 (no overlap). A new request is accepted no earlier than the cycle after the handshake.
- gcd_data_in=0 and gcd_start=0 in every state other than those listed above.
- Latency: request accepted at edge T; gcd_start high T..T+1; B on bus T+1..T+2; done first sampled at T+3. rsp_valid rises one cycle after done is sampled. Bypass: rsp_valid in the cycle after acceptance.
- Counter never wraps: it saturates by leaving WAIT.
- Unused state encodings -> IDLE on next edge, with no outputs asserted.

Decomposition:
- Package gcd_pkg: state enum type gcd_seq_state_t, default WIDTH, default TIMEOUT.
- Timeout counter as sub-module gcd_timeout_counter (clear, enable, expire at limit). Everything else stays in one FSM module.

Test Plan:
- (48,18); engine model raises done 5 cycles after B with result 6 -> one gcd_start pulse, bus 48 then 18, rsp_gcd=6, rsp_timeout=0.
- (0,35), then (21,0), then (0,0) -> responses 35, 21, 0; gcd_start never asserted; each rsp_valid one cycle after acceptance.
- TIMEOUT=8; engine never raises done -> exactly 8 WAIT cycles, then rsp_valid with rsp_timeout=1, rsp_gcd=0; next request accepted normally.
- (100,75) with rsp_ready held low 3 cycles after rsp_valid -> rsp_gcd=25 stable throughout; req_ready=0 with a pending req_valid; request accepted after the handshake.
- gcd_done stuck high from the previous job during LOAD_B -> ignored; result taken only from WAIT-state done. Also: done and timeout expiry in the same cycle -> done result, rsp_timeout=0.
- rst pulsed for 1 cycle during WAIT -> next cycle IDLE, rsp_valid=0, req_ready=1; a subsequent (9,6) completes with rsp_gcd=3.
